// File: rtl/prog_sequencer.sv
// Program-level sequencer ahead of instruction fetch: Start/Done handshake with the
// test bench, per-program base selection, branch muxing and RUN cycle counting.
module prog_sequencer #(
    parameter int PC_W      = 10,
    parameter int NUM_PROGS = 3,
    parameter int P0_BASE   = 0,
    parameter int P1_BASE   = 256,
    parameter int P2_BASE   = 512,
    parameter int P3_BASE   = 768,
    parameter int CYC_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BrEn,
    input  logic             ALU_flag,
    input  logic [PC_W-1:0]  BrTarget,
    output logic             FetchHold,
    output logic             BranchAbs,
    output logic [PC_W-1:0]  Target,
    output logic             Done,
    output logic [1:0]       ProgIdx,
    output logic [CYC_W-1:0] CycleCount
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic             done_nxt;
    logic [1:0]       idx_nxt;
    logic [CYC_W-1:0] cc_nxt;
    logic             br_take;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (int'(idx) >= NUM_PROGS - 1) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [PC_W-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return PC_W'(P0_BASE);
            2'd1:    return PC_W'(P1_BASE);
            2'd2:    return PC_W'(P2_BASE);
            default: return PC_W'(P3_BASE);
        endcase
    endfunction

    assign br_take = BrEn & ALU_flag;

    always_comb begin
        state_nxt = state;
        done_nxt  = Done;
        idx_nxt   = ProgIdx;
        cc_nxt    = CycleCount;
        FetchHold = 1'b1;
        BranchAbs = 1'b0;
        Target    = '0;
        case (state)
            IDLE: begin
                if (Start) state_nxt = ARM;
            end
            ARM: begin
                done_nxt = 1'b0;
                cc_nxt   = '0;
                // Start has dropped: one-cycle absolute jump to the program base
                if (!Start) begin
                    FetchHold = 1'b0;
                    BranchAbs = 1'b1;
                    Target    = base_of(ProgIdx);
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cc_nxt = sat_inc(CycleCount);
                // Halt outranks both a taken branch and an abort request
                if (Halt) begin
                    state_nxt = FIN;
                    done_nxt  = 1'b1;
                    idx_nxt   = next_idx(ProgIdx);
                end else begin
                    FetchHold = 1'b0;
                    BranchAbs = br_take;
                    Target    = br_take ? BrTarget : '0;
                    if (Start) begin
                        state_nxt = ARM;
                        cc_nxt    = '0;
                    end
                end
            end
            FIN: begin
                if (Start) begin
                    state_nxt = ARM;
                    done_nxt  = 1'b0;
                    cc_nxt    = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            Done       <= 1'b0;
            ProgIdx    <= 2'd0;
            CycleCount <= '0;
        end else begin
            state      <= state_nxt;
            Done       <= done_nxt;
            ProgIdx    <= idx_nxt;
            CycleCount <= cc_nxt;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: directed steps queue hand-computed
// expectations; a negedge monitor pops and compares against both instances.
module tb_prog_sequencer;

    typedef struct {
        logic        fh;
        logic        ba;
        logic [9:0]  tgt;
        logic        done;
        logic [1:0]  idx;
        logic [15:0] cc;
        string       name;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0, Halt = 1'b0, BrEn = 1'b0, ALU_flag = 1'b0;
    logic [9:0]  BrTarget = '0;
    logic        FetchHold, BranchAbs, Done;
    logic [9:0]  Target;
    logic [1:0]  ProgIdx;
    logic [15:0] CycleCount;

    logic        Start2 = 1'b0, Halt2 = 1'b0;
    logic        FetchHold2, BranchAbs2, Done2;
    logic [9:0]  Target2;
    logic [1:0]  ProgIdx2;
    logic [3:0]  CycleCount2;

    exp_t q[$];
    exp_t q2[$];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    prog_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .BrEn(BrEn),
        .ALU_flag(ALU_flag), .BrTarget(BrTarget), .FetchHold(FetchHold),
        .BranchAbs(BranchAbs), .Target(Target), .Done(Done), .ProgIdx(ProgIdx),
        .CycleCount(CycleCount)
    );

    prog_sequencer #(.NUM_PROGS(1), .CYC_W(4)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start2), .Halt(Halt2), .BrEn(1'b0),
        .ALU_flag(1'b0), .BrTarget(10'd0), .FetchHold(FetchHold2),
        .BranchAbs(BranchAbs2), .Target(Target2), .Done(Done2), .ProgIdx(ProgIdx2),
        .CycleCount(CycleCount2)
    );

    task automatic chk(input string nm, input string field, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h at %0t", nm, field, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "FetchHold", 16'(FetchHold), 16'(e.fh));
            chk(e.name, "BranchAbs", 16'(BranchAbs), 16'(e.ba));
            chk(e.name, "Target", 16'(Target), 16'(e.tgt));
            chk(e.name, "Done", 16'(Done), 16'(e.done));
            chk(e.name, "ProgIdx", 16'(ProgIdx), 16'(e.idx));
            chk(e.name, "CycleCount", CycleCount, e.cc);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            chk(e.name, "FetchHold", 16'(FetchHold2), 16'(e.fh));
            chk(e.name, "BranchAbs", 16'(BranchAbs2), 16'(e.ba));
            chk(e.name, "Target", 16'(Target2), 16'(e.tgt));
            chk(e.name, "Done", 16'(Done2), 16'(e.done));
            chk(e.name, "ProgIdx", 16'(ProgIdx2), 16'(e.idx));
            chk(e.name, "CycleCount", 16'(CycleCount2), e.cc);
        end
    end

    function automatic exp_t mk(input logic fh, ba, input logic [9:0] t, input logic d,
                                input logic [1:0] i, input logic [15:0] c, input string nm);
        exp_t e;
        e.fh = fh; e.ba = ba; e.tgt = t; e.done = d; e.idx = i; e.cc = c; e.name = nm;
        return e;
    endfunction

    task automatic step(input logic st, ha, be, fl, input logic [9:0] bt,
                        input logic fh, ba, input logic [9:0] t, input logic d,
                        input logic [1:0] i, input logic [15:0] c, input string nm);
        Start = st; Halt = ha; BrEn = be; ALU_flag = fl; BrTarget = bt;
        q.push_back(mk(fh, ba, t, d, i, c, nm));
        @(posedge Clk); #1;
    endtask

    task automatic step2(input logic st, ha, input logic fh, ba, input logic d,
                         input logic [15:0] c, input string nm);
        Start2 = st; Halt2 = ha;
        q2.push_back(mk(fh, ba, 10'd0, d, 2'd0, c, nm));
        @(posedge Clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        step(0,0,0,0,0,   1,0,0,   0,0,0, "reset_idle");
        for (int k = 0; k < 3; k++) step(1,0,0,0,0, 1,0,0, 0,0,0, "arm_hold");
        step(0,0,0,0,0,   0,1,0,   0,0,0, "jump_p0");
        step(0,0,1,1,10'h05A, 0,1,10'h05A, 0,0,0, "br_taken");
        step(0,0,1,0,10'h05A, 0,0,0, 0,0,1, "br_not_taken");
        for (int c = 2; c <= 18; c++) step(0,0,0,0,0, 0,0,0, 0,0,16'(c), "run_count");
        step(0,1,0,0,0,   1,0,0,   0,0,19, "halt_p0");
        step(0,0,0,0,0,   1,0,0,   1,1,20, "fin_p0");
        step(0,0,0,0,0,   1,0,0,   1,1,20, "fin_hold");
        step(1,0,0,0,0,   1,0,0,   1,1,20, "fin_start");
        step(0,0,0,0,0,   0,1,256, 0,1,0,  "jump_p1");
        step(0,0,0,0,0,   0,0,0,   0,1,0,  "run_p1");
        step(0,1,1,1,10'h123, 1,0,0, 0,1,1, "halt_vs_branch");
        step(1,0,0,0,0,   1,0,0,   1,2,2,  "fin_p1");
        step(0,0,0,0,0,   0,1,512, 0,2,0,  "jump_p2");
        step(0,0,0,0,0,   0,0,0,   0,2,0,  "run_p2");
        step(0,0,0,0,0,   0,0,0,   0,2,1,  "run_p2");
        step(1,0,0,0,0,   0,0,0,   0,2,2,  "abort");
        step(1,0,0,0,0,   1,0,0,   0,2,0,  "abort_arm");
        step(0,0,0,0,0,   0,1,512, 0,2,0,  "rejump_p2");
        step(0,0,0,0,0,   0,0,0,   0,2,0,  "run_p2b");
        step(0,0,0,0,0,   0,0,0,   0,2,1,  "run_p2b");
        step(1,1,0,0,0,   1,0,0,   0,2,2,  "halt_and_start");
        step(1,0,0,0,0,   1,0,0,   1,0,3,  "fin_p2_wrap");
        step(0,0,0,0,0,   0,1,0,   0,0,0,  "jump_p0_again");
        step(0,1,0,0,0,   1,0,0,   0,0,0,  "halt_p0b");
        step(1,0,0,0,0,   1,0,0,   1,1,1,  "fin_p0b");
        step(0,0,0,0,0,   0,1,256, 0,1,0,  "jump_p1b");
        for (int c = 0; c <= 2; c++) step(0,0,0,0,0, 0,0,0, 0,1,16'(c), "run_p1b");

        // mid-cycle reset: no clock edge before the monitor samples
        Start = 0; Halt = 0; BrEn = 0; ALU_flag = 0;
        #2 Reset = 1'b1;
        q.push_back(mk(1,0,0, 0,0,0, "async_reset"));
        @(posedge Clk); #1;
        step(0,0,0,0,0,   1,0,0,   0,0,0,  "reset_held");
        Reset = 1'b0;

        step2(1,0, 1,0, 0,0,  "s_idle_start");
        step2(0,0, 0,1, 0,0,  "s_jump");
        for (int c = 0; c < 20; c++) step2(0,0, 0,0, 0, (c > 15) ? 16'd15 : 16'(c), "sat_count");
        step2(0,1, 1,0, 0,15, "s_halt");
        step2(0,0, 1,0, 1,15, "s_fin_wrap");

        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (q.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d/%0d entries, required 0", q.size(), q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Program-level sequencer that sits directly upstream of the instruction fetch stage.
- Owns the test-bench Start/Done handshake, selects the base address of the next program in the series, and drives the fetch stage's hold, absolute-jump and target inputs.
- Also muxes the decoded conditional branch into the fetch jump path and counts execution cycles per program.

Parameters:
PC_W, 10, program counter / target width
NUM_PROGS, 3, number of programs in the series (1..4)
P0_BASE, 0, start address of program 0
P1_BASE, 256, start address of program 1
P2_BASE, 512, start address of program 2
P3_BASE, 768, start address of program 3
CYC_W, 16, cycle counter width

Ports:
Clk  in  1  clock; all state changes on posedge
Reset  in  1  asynchronous, active-high reset
Start  in  1  test-bench request to begin the next program; level, held one or more cycles
Halt  in  1  decoded halt/done instruction at current PC
BrEn  in  1  decoded conditional-branch instruction at current PC
ALU_flag  in  1  branch condition from ALU
BrTarget  in  PC_W  absolute branch target from decode
FetchHold  out  1  drives the fetch stage's Start input (1 = PC holds)
BranchAbs  out  1  drives the fetch stage's BranchAbs input
Target  out  PC_W  drives the fetch stage's Target input
Done  out  1  program-complete flag to the test bench
ProgIdx  out  2  index of the current/next program
CycleCount  out  CYC_W  cycles spent in RUN for the current program

Behaviour:
- States: IDLE, ARM, RUN, FIN, held in a state register. Next-state and counter updates happen on posedge Clk.
- Outputs FetchHold, BranchAbs and Target are combinational from state and inputs. Done, ProgIdx and CycleCount are registered.
- Reset (async, any state, including mid-RUN): state=IDLE, Done=0, ProgIdx=0, CycleCount=0.
- While in IDLE/ARM/FIN: FetchHold=1.
- While in RUN, or in ARM with Start=0: FetchHold=0.
- IDLE: FetchHold=1, BranchAbs=0, Target=0. Start=1 -> ARM.
- ARM, Start=1: FetchHold=1, BranchAbs=0. Stay in ARM, keep CycleCount=0, keep Done=0.
- ARM, Start=0: BranchAbs=1, Target=base[ProgIdx], FetchHold=0 for exactly one cycle. Fetch loads the base at this edge; next state RUN.
- RUN outputs: BranchAbs = BrEn & ALU_flag, Target = BrTarget (Target = 0 when BranchAbs=0).
- RUN counting: CycleCount increments by 1 each RUN cycle and saturates at all-ones with no wrap.
- RUN, Halt=1: BranchAbs forced 0 (Halt wins over a simultaneous branch), FetchHold=1. Next edge: state=FIN, Done<=1, ProgIdx<=ProgIdx+1, wrapping to 0 after NUM_PROGS-1.
- RUN, Start=1 (abort) with Halt=0: next state ARM, Done stays 0, ProgIdx unchanged, CycleCount<=0.
- RUN, Start=1 and Halt=1 together: Halt wins; go to FIN. Start is then honoured from FIN.
- FIN: FetchHold=1, BranchAbs=0, Done held 1, CycleCount frozen. Start=1 -> ARM, with Done<=0 and CycleCount<=0 on that edge.
- base[] mapping: 0..3 -> P0..P3_BASE. ProgIdx never reaches values >= NUM_PROGS.
- Latency:
  - Start falling edge to first instruction at base: 1 cycle (ARM jump cycle), then RUN.
  - Halt decode to Done=1: 1 cycle.

Test Plan:
- Reset, hold Start=1 3 cycles then 0 -> ARM cycle shows BranchAbs=1, Target=0, FetchHold=0; next cycle state RUN, CycleCount=0 then 1, 2, ...
- In RUN, BrEn=1, ALU_flag=1, BrTarget=0x05A -> BranchAbs=1, Target=0x05A same cycle. With ALU_flag=0 -> BranchAbs=0. CycleCount keeps incrementing.
- Run prog 0, Halt=1 after 20 RUN cycles -> next edge Done=1, ProgIdx=1, CycleCount=20 frozen. Then Start pulse -> Done=0, the jump cycle shows Target=256.
- Complete 3 programs (NUM_PROGS=3) -> ProgIdx sequence 0, 1, 2, 0; fourth jump Target=0.
- Halt=1 and BrEn=ALU_flag=1 in the same cycle -> BranchAbs=0, FetchHold=1, FIN entered. Separately, Start=1 mid-RUN -> ARM, Done stays 0, ProgIdx unchanged.
- Assert Reset asynchronously mid-RUN (between edges) -> Done=0, ProgIdx=0, CycleCount=0 immediately, FetchHold=1. Separately, force CycleCount to 0xFFFE in RUN -> reaches 0xFFFF and holds.
